power_sequence_ctrl: RTL and testbench

//  Board power sequencer downstream of the button/BMC request detector. Turns debounced

---
 rtl/power_sequence_ctrl_pkg.sv | 29 ++
 rtl/power_sequence_ctrl_event_capture.sv | 35 +++
 rtl/power_sequence_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_power_sequence_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_sequence_ctrl_pkg.sv
// Shared definitions for the board power sequencer: state encoding and timer helpers.
package power_sequence_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int TIMER_W = 16;

    // State codes double as the debug/BMC readout value on pwr_state.
    typedef enum logic [STATE_W-1:0] {
        S_OFF     = 3'd0,
        S_UP      = 3'd1,
        S_RSTHOLD = 3'd2,
        S_ON      = 3'd3,
        S_REBOOT  = 3'd4,
        S_DOWN    = 3'd5,
        S_FAULT   = 3'd6
    } pwr_state_e;

    // Millisecond timer increment that sticks at all-ones instead of wrapping.
    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] value);
        logic [TIMER_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/power_sequence_ctrl_event_capture.sv
// Request input conditioner: two-flop synchroniser followed by an asserting-edge detector.
// Produces a single-cycle event when the synchronised input enters its active level.
module power_sequence_ctrl_event_capture #(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_event
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_now_active;
    logic w_prev_active;

    // Synchroniser and history flops; reset to the idle level so nothing fires out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= ACTIVE_LOW;
            r_sync <= ACTIVE_LOW;
            r_prev <= ACTIVE_LOW;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_now_active  = r_sync ^ ACTIVE_LOW;
    assign w_prev_active = r_prev ^ ACTIVE_LOW;
    assign o_event       = w_now_active & ~w_prev_active;

endmodule

// File: rtl/power_sequence_ctrl.sv
// Board power sequencer: turns request events into an ordered rail up/down sequence,
// watches rail power-good, and drives the CPU reset. All outputs are registered and
// computed from the next state so they change on the same edge as the state.
module power_sequence_ctrl
    import power_sequence_ctrl_pkg::*;
#(
    parameter int NUM_RAILS     = 4,
    parameter int STEP_DLY_MS   = 10,
    parameter int PG_TIMEOUT_MS = 100,
    parameter int RST_HOLD_MS   = 50
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 int_1ms_en,
    input  logic                 pwr_on_off_n,
    input  logic                 pwr_force_off_n,
    input  logic                 normal_reboot_n,
    input  logic                 host_reboot_req,
    input  logic [NUM_RAILS-1:0] pg_in,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 sys_rst_n,
    output logic                 pwr_fault,
    output logic [2:0]           fault_rail,
    output logic [2:0]           pwr_state
);

    localparam logic [2:0]  LAST_IDX   = 3'(NUM_RAILS - 1);
    localparam logic [15:0] STEP_DLY   = 16'(STEP_DLY_MS);
    localparam logic [15:0] PG_TIMEOUT = 16'(PG_TIMEOUT_MS);
    localparam logic [15:0] RST_HOLD   = 16'(RST_HOLD_MS);

    // Rails strictly below 'count' enabled; rail 0 is always the first on and last off.
    function automatic logic [NUM_RAILS-1:0] rails_below(input logic [3:0] count);
        logic [NUM_RAILS-1:0] mask;
        for (int i = 0; i < NUM_RAILS; i++) begin
            mask[i] = (4'(i) < count);
        end
        return mask;
    endfunction

    pwr_state_e           r_state;
    pwr_state_e           w_state_nx;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_nx;
    logic [15:0]          r_timer;
    logic [15:0]          w_timer_nx;
    logic                 r_settle;
    logic                 w_settle_nx;
    logic                 w_restart;
    logic                 r_pwr_fault;
    logic                 w_fault_nx;
    logic [2:0]           r_fault_rail;
    logic [2:0]           w_fault_rail_nx;
    logic [NUM_RAILS-1:0] r_rail_en;
    logic [NUM_RAILS-1:0] w_rail_nx;
    logic                 r_sys_rst_n;
    logic                 w_rst_n_nx;

    logic [NUM_RAILS-1:0] r_pg_meta;
    logic [NUM_RAILS-1:0] r_pg_sync;
    logic [7:0]           w_pg8;
    logic                 w_pg_fail_any;
    logic [2:0]           w_pg_low_idx;

    logic w_ev_onoff;
    logic w_ev_force;
    logic w_ev_nreboot;
    logic w_ev_hreboot;
    logic w_ev_reboot;

    power_sequence_ctrl_event_capture #(.ACTIVE_LOW(1'b1)) u_cap_onoff (
        .i_clk(clock), .i_rst_n(reset), .i_async(pwr_on_off_n), .o_event(w_ev_onoff)
    );
    power_sequence_ctrl_event_capture #(.ACTIVE_LOW(1'b1)) u_cap_force (
        .i_clk(clock), .i_rst_n(reset), .i_async(pwr_force_off_n), .o_event(w_ev_force)
    );
    power_sequence_ctrl_event_capture #(.ACTIVE_LOW(1'b1)) u_cap_nreboot (
        .i_clk(clock), .i_rst_n(reset), .i_async(normal_reboot_n), .o_event(w_ev_nreboot)
    );
    power_sequence_ctrl_event_capture #(.ACTIVE_LOW(1'b0)) u_cap_hreboot (
        .i_clk(clock), .i_rst_n(reset), .i_async(host_reboot_req), .o_event(w_ev_hreboot)
    );

    assign w_ev_reboot = w_ev_nreboot | w_ev_hreboot;

    // Two-flop synchroniser for the asynchronous power-good pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pg_meta <= '0;
            r_pg_sync <= '0;
        end else begin
            r_pg_meta <= pg_in;
            r_pg_sync <= r_pg_meta;
        end
    end

    // Power-good views: padded vector for rail-index lookup, any-fail flag, lowest failing rail.
    always_comb begin
        w_pg8        = 8'hFF;
        w_pg_low_idx = 3'd0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            w_pg8[i] = r_pg_sync[i];
        end
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (!r_pg_sync[i]) begin
                w_pg_low_idx = 3'(i);
            end else begin
                w_pg_low_idx = w_pg_low_idx;
            end
        end
        w_pg_fail_any = ~(&r_pg_sync);
    end

    // Next-state, rail index, fault capture and ms timer; force-off overrides everything.
    always_comb begin
        w_state_nx      = r_state;
        w_idx_nx        = r_idx;
        w_settle_nx     = r_settle;
        w_restart       = 1'b0;
        w_fault_nx      = r_pwr_fault;
        w_fault_rail_nx = r_fault_rail;
        w_timer_nx      = r_timer;
        if (w_ev_force) begin
            w_state_nx = S_OFF;
            w_idx_nx   = 3'd0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_ev_onoff) begin
                        w_state_nx = S_UP;
                        w_idx_nx   = 3'd0;
                    end else begin
                        w_state_nx = S_OFF;
                    end
                end
                S_UP: begin
                    if (!r_settle && !w_pg8[r_idx] && (r_timer >= PG_TIMEOUT)) begin
                        w_state_nx      = S_FAULT;
                        w_fault_nx      = 1'b1;
                        w_fault_rail_nx = r_idx;
                    end else if (w_ev_onoff) begin
                        w_state_nx = S_DOWN;
                    end else if (!r_settle) begin
                        // Power-good seen: restart the timer to measure the settle gap.
                        if (w_pg8[r_idx]) begin
                            w_settle_nx = 1'b1;
                            w_restart   = 1'b1;
                        end else begin
                            w_settle_nx = 1'b0;
                        end
                    end else if (r_timer >= STEP_DLY) begin
                        if (r_idx == LAST_IDX) begin
                            w_state_nx = S_RSTHOLD;
                        end else begin
                            w_idx_nx = r_idx + 3'd1;
                        end
                    end else begin
                        w_state_nx = S_UP;
                    end
                end
                S_RSTHOLD: begin
                    if (r_timer >= RST_HOLD) begin
                        w_state_nx = S_ON;
                    end else begin
                        w_state_nx = S_RSTHOLD;
                    end
                end
                S_ON: begin
                    if (w_pg_fail_any) begin
                        w_state_nx      = S_FAULT;
                        w_fault_nx      = 1'b1;
                        w_fault_rail_nx = w_pg_low_idx;
                    end else if (w_ev_onoff) begin
                        w_state_nx = S_DOWN;
                        w_idx_nx   = LAST_IDX;
                    end else if (w_ev_reboot) begin
                        w_state_nx = S_REBOOT;
                    end else begin
                        w_state_nx = S_ON;
                    end
                end
                S_REBOOT: begin
                    if (w_pg_fail_any) begin
                        w_state_nx      = S_FAULT;
                        w_fault_nx      = 1'b1;
                        w_fault_rail_nx = w_pg_low_idx;
                    end else if (r_timer >= RST_HOLD) begin
                        w_state_nx = S_ON;
                    end else begin
                        w_state_nx = S_REBOOT;
                    end
                end
                S_DOWN: begin
                    if (r_timer >= STEP_DLY) begin
                        if (r_idx == 3'd0) begin
                            w_state_nx = S_OFF;
                        end else begin
                            w_idx_nx = r_idx - 3'd1;
                        end
                    end else begin
                        w_state_nx = S_DOWN;
                    end
                end
                S_FAULT: begin
                    if (w_ev_onoff) begin
                        w_state_nx      = S_OFF;
                        w_idx_nx        = 3'd0;
                        w_fault_nx      = 1'b0;
                        w_fault_rail_nx = 3'd0;
                    end else begin
                        w_state_nx = S_FAULT;
                    end
                end
                default: begin
                    w_state_nx = S_OFF;
                    w_idx_nx   = 3'd0;
                end
            endcase
        end

        if ((w_state_nx != r_state) || (w_idx_nx != r_idx)) begin
            w_settle_nx = 1'b0;
            w_timer_nx  = 16'd0;
        end else if (w_restart) begin
            w_timer_nx = 16'd0;
        end else if (int_1ms_en) begin
            w_timer_nx = sat_inc(r_timer);
        end else begin
            w_timer_nx = r_timer;
        end
    end

    // Output decode from the upcoming state so rails and reset move with the state change.
    always_comb begin
        w_rail_nx  = '0;
        w_rst_n_nx = 1'b0;
        case (w_state_nx)
            S_OFF:     w_rail_nx = '0;
            S_UP:      w_rail_nx = rails_below({1'b0, w_idx_nx} + 4'd1);
            S_RSTHOLD: w_rail_nx = {NUM_RAILS{1'b1}};
            S_ON: begin
                w_rail_nx  = {NUM_RAILS{1'b1}};
                w_rst_n_nx = 1'b1;
            end
            S_REBOOT:  w_rail_nx = {NUM_RAILS{1'b1}};
            S_DOWN:    w_rail_nx = rails_below({1'b0, w_idx_nx});
            S_FAULT:   w_rail_nx = '0;
            default:   w_rail_nx = '0;
        endcase
    end

    // State, sequencing registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_OFF;
            r_idx        <= 3'd0;
            r_timer      <= 16'd0;
            r_settle     <= 1'b0;
            r_pwr_fault  <= 1'b0;
            r_fault_rail <= 3'd0;
            r_rail_en    <= '0;
            r_sys_rst_n  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_timer      <= w_timer_nx;
            r_settle     <= w_settle_nx;
            r_pwr_fault  <= w_fault_nx;
            r_fault_rail <= w_fault_rail_nx;
            r_rail_en    <= w_rail_nx;
            r_sys_rst_n  <= w_rst_n_nx;
        end
    end

    assign rail_en    = r_rail_en;
    assign sys_rst_n  = r_sys_rst_n;
    assign pwr_fault  = r_pwr_fault;
    assign fault_rail = r_fault_rail;
    assign pwr_state  = r_state;

endmodule

// File: tb/tb_power_sequence_ctrl.sv
// Directed bench for power_sequence_ctrl: expected output changes are queued when a
// stimulus is applied and compared (value and delay) as the DUT outputs change.
module tb_power_sequence_ctrl;

    localparam int NR   = 4;
    localparam int TICK = 20;

    logic          clock;
    logic          reset;
    logic          int_1ms_en;
    logic          pwr_on_off_n;
    logic          pwr_force_off_n;
    logic          normal_reboot_n;
    logic          host_reboot_req;
    logic [NR-1:0] pg_in;
    logic [NR-1:0] rail_en;
    logic          sys_rst_n;
    logic          pwr_fault;
    logic [2:0]    fault_rail;
    logic [2:0]    pwr_state;

    logic [NR-1:0] pg_block;
    logic [NR-1:0] pg_kill;
    logic [11:0]   obs;

    typedef struct {
        string       tag;
        logic [11:0] exp;
        int          min_c;
        int          max_c;
    } exp_t;

    exp_t        sb[$];
    int          n_pass;
    int          n_total;
    int unsigned cyc;
    int unsigned t_mark;
    logic [11:0] last_b;

    power_sequence_ctrl #(
        .NUM_RAILS(NR), .STEP_DLY_MS(2), .PG_TIMEOUT_MS(5), .RST_HOLD_MS(3)
    ) dut (
        .clock(clock), .reset(reset), .int_1ms_en(int_1ms_en),
        .pwr_on_off_n(pwr_on_off_n), .pwr_force_off_n(pwr_force_off_n),
        .normal_reboot_n(normal_reboot_n), .host_reboot_req(host_reboot_req),
        .pg_in(pg_in), .rail_en(rail_en), .sys_rst_n(sys_rst_n),
        .pwr_fault(pwr_fault), .fault_rail(fault_rail), .pwr_state(pwr_state)
    );

    assign obs = {rail_en, sys_rst_n, pwr_fault, fault_rail, pwr_state};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // 1 ms tick: one clock high every TICK clocks.
    initial begin
        int_1ms_en = 1'b0;
        forever begin
            repeat (TICK - 1) @(negedge clock);
            int_1ms_en = 1'b1;
            @(negedge clock);
            int_1ms_en = 1'b0;
        end
    end

    // Rail model: PG rises one ms after its enable, drops with it; block/kill hold it low.
    initial begin
        int cnt [NR];
        pg_in = '0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NR; i++) begin
                if (rail_en[i] === 1'b1) cnt[i] = (cnt[i] < 1000) ? cnt[i] + 1 : cnt[i];
                else cnt[i] = 0;
                pg_in[i] = (cnt[i] >= TICK) && !pg_block[i] && !pg_kill[i];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bnd(input logic [3:0] r, input logic rst,
                                        input logic f, input logic [2:0] fr,
                                        input logic [2:0] st);
        return {r, rst, f, fr, st};
    endfunction

    task automatic push(input string tag, input logic [11:0] e, input int mn, input int mx);
        exp_t x;
        x.tag = tag; x.exp = e; x.min_c = mn; x.max_c = mx;
        sb.push_back(x);
    endtask

    task automatic mark();
        t_mark = cyc;
        last_b = obs;
    endtask

    // Wait for the next output change and compare its value and delay with the queue head.
    task automatic check_next();
        exp_t e;
        bit   seen;
        int   d;
        e = sb.pop_front();
        seen = 1'b0;
        for (int k = 0; k < e.max_c + 20 && !seen; k++) begin
            @(negedge clock);
            if (obs !== last_b) seen = 1'b1;
        end
        n_total++;
        assert (seen) n_pass++;
        else $error("FAIL %s_change: no output change, bundle=%h required=%h", e.tag, obs, e.exp);
        if (seen) begin
            d = int'(cyc - t_mark);
            t_mark = cyc;
            last_b = obs;
            n_total++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: bundle=%h required=%h", e.tag, obs, e.exp);
            n_total++;
            assert (d >= e.min_c && d <= e.max_c) n_pass++;
            else $error("FAIL %s_time: delay=%0d cycles required %0d..%0d", e.tag, d, e.min_c, e.max_c);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) check_next();
    endtask

    task automatic check_now();
        exp_t e;
        e = sb.pop_front();
        n_total++;
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s: bundle=%h required=%h", e.tag, obs, e.exp);
        last_b = obs;
    endtask

    task automatic check_quiet(input string tag, input int n);
        bit moved;
        moved = 1'b0;
        repeat (n) begin
            @(negedge clock);
            if (obs !== last_b) moved = 1'b1;
        end
        n_total++;
        assert (!moved) n_pass++;
        else $error("FAIL %s: bundle=%h changed from %h", tag, obs, last_b);
    endtask

    task automatic pulse(input bit onoff, input bit force_off, input bit nreboot);
        mark();
        if (onoff) pwr_on_off_n = 1'b0;
        if (force_off) pwr_force_off_n = 1'b0;
        if (nreboot) normal_reboot_n = 1'b0;
        repeat (2) @(negedge clock);
        pwr_on_off_n    = 1'b1;
        pwr_force_off_n = 1'b1;
        normal_reboot_n = 1'b1;
    endtask

    task automatic push_power_up();
        push("up_r0",   bnd(4'b0001, 1'b0, 1'b0, 3'd0, 3'd1), 2, 4);
        push("up_r1",   bnd(4'b0011, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        push("up_r2",   bnd(4'b0111, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        push("up_r3",   bnd(4'b1111, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        push("rsthold", bnd(4'b1111, 1'b0, 1'b0, 3'd0, 3'd2), 40, 70);
        push("on",      bnd(4'b1111, 1'b1, 1'b0, 3'd0, 3'd3), 38, 66);
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        reset           = 1'b0;
        pwr_on_off_n    = 1'b1;
        pwr_force_off_n = 1'b1;
        normal_reboot_n = 1'b1;
        host_reboot_req = 1'b0;
        pg_block        = '0;
        pg_kill         = '0;
        t_mark          = 0;

        repeat (4) @(negedge clock);
        push("reset_state", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 0, 0);
        check_now();
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Power up to S_ON.
        pulse(1'b1, 1'b0, 1'b0);
        push_power_up();
        drain();

        // Host warm reboot; a normal reboot edge inside the hold must not extend it.
        mark();
        host_reboot_req = 1'b1;
        push("hreboot_enter", bnd(4'b1111, 1'b0, 1'b0, 3'd0, 3'd4), 2, 4);
        check_next();
        repeat (28) @(negedge clock);
        normal_reboot_n = 1'b0;
        repeat (2) @(negedge clock);
        normal_reboot_n = 1'b1;
        push("hreboot_exit", bnd(4'b1111, 1'b1, 1'b0, 3'd0, 3'd3), 38, 66);
        check_next();
        host_reboot_req = 1'b0;
        check_quiet("hreboot_release_quiet", 120);

        // Normal reboot from S_ON.
        pulse(1'b0, 1'b0, 1'b1);
        push("nreboot_enter", bnd(4'b1111, 1'b0, 1'b0, 3'd0, 3'd4), 2, 4);
        push("nreboot_exit",  bnd(4'b1111, 1'b1, 1'b0, 3'd0, 3'd3), 38, 66);
        drain();

        // Orderly power down.
        pulse(1'b1, 1'b0, 1'b0);
        push("down_r3", bnd(4'b0111, 1'b0, 1'b0, 3'd0, 3'd5), 2, 4);
        push("down_r2", bnd(4'b0011, 1'b0, 1'b0, 3'd0, 3'd5), 18, 44);
        push("down_r1", bnd(4'b0001, 1'b0, 1'b0, 3'd0, 3'd5), 18, 44);
        push("down_r0", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd5), 18, 44);
        push("down_off", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 18, 44);
        drain();

        // PG timeout on rail 2, no auto-retry, cleared by on_off.
        pg_block = 4'b0100;
        pulse(1'b1, 1'b0, 1'b0);
        push("to_r0", bnd(4'b0001, 1'b0, 1'b0, 3'd0, 3'd1), 2, 4);
        push("to_r1", bnd(4'b0011, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        push("to_r2", bnd(4'b0111, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        push("to_fault", bnd(4'b0000, 1'b0, 1'b1, 3'd2, 3'd6), 78, 106);
        drain();
        pg_block = '0;
        check_quiet("fault_no_retry", 200);
        pulse(1'b1, 1'b0, 1'b0);
        push("fault_clear", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 2, 4);
        drain();

        // Force off at rail index 1 together with on_off: force wins, nothing queued.
        pulse(1'b1, 1'b0, 1'b0);
        push("fo_r0", bnd(4'b0001, 1'b0, 1'b0, 3'd0, 3'd1), 2, 4);
        push("fo_r1", bnd(4'b0011, 1'b0, 1'b0, 3'd0, 3'd1), 40, 70);
        drain();
        pulse(1'b1, 1'b1, 1'b0);
        push("force_off", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 2, 4);
        drain();
        check_quiet("force_off_quiet", 200);

        // PG loss on rail 3 while on.
        pulse(1'b1, 1'b0, 1'b0);
        push_power_up();
        drain();
        mark();
        pg_kill = 4'b1000;
        push("pg_drop", bnd(4'b0000, 1'b0, 1'b1, 3'd3, 3'd6), 2, 5);
        check_next();
        pulse(1'b1, 1'b0, 1'b0);
        push("pg_drop_clear", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 2, 4);
        drain();
        pg_kill = '0;

        // Asynchronous reset in the middle of power down.
        pulse(1'b1, 1'b0, 1'b0);
        push_power_up();
        drain();
        pulse(1'b1, 1'b0, 1'b0);
        push("rd_r3", bnd(4'b0111, 1'b0, 1'b0, 3'd0, 3'd5), 2, 4);
        push("rd_r2", bnd(4'b0011, 1'b0, 1'b0, 3'd0, 3'd5), 18, 44);
        drain();
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        push("async_reset", bnd(4'b0000, 1'b0, 1'b0, 3'd0, 3'd0), 0, 0);
        check_now();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        mark();
        check_quiet("after_reset_quiet", 80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
